waypoint_sequencer: RTL

Waypoint sequencer feeding the target-coordinate inputs (dX, dY) of the motor-drive stage, replacing the fixed destination constants. Holds a small table of (x, y) waypoints loaded over a simple write port, presents one waypoint at a time, and advances when the motor drive raises `arrived`. After each arrival it holds the target for a fixed dwell time, then moves on. At the end of the table it stops, or wraps to waypoint 0 when looping is enabled.

---
 rtl/waypoint_sequencer_if.sv | 29 ++
 rtl/waypoint_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/waypoint_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : waypoint_sequencer_if
// Description : Waypoint table write port and motor-drive target/arrival link.
// Revision    : 1.0 - initial release
// ============================================================================
interface waypoint_sequencer_if #(
    parameter int W  = 33,
    parameter int AW = 2
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_x;
    logic [W-1:0]  wr_y;
    logic          arrived;
    logic [W-1:0]  dX;
    logic [W-1:0]  dY;

    modport master (
        output wr_en, wr_addr, wr_x, wr_y, arrived,
        input  dX, dY
    );

    modport slave (
        input  wr_en, wr_addr, wr_x, wr_y, arrived,
        output dX, dY
    );
endinterface
`default_nettype wire

// File: rtl/waypoint_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : waypoint_sequencer
// Description : Steps the motor-drive target through a table of waypoints,
//               dwelling at each one after arrival.
// Revision    : 1.0 - initial release
// ============================================================================
module waypoint_sequencer #(
    parameter int W     = 33,
    parameter int AW    = 2,
    parameter int DWELL = 1000,
    parameter int GUARD = 2
) (
    input  wire logic          outclk,
    input  wire logic          rst_n,
    input  wire logic          start,
    input  wire logic          abort,
    input  wire logic          loop,
    input  wire logic [AW-1:0] wp_last,
    waypoint_sequencer_if.slave bus,
    output logic [AW-1:0]      wp_idx,
    output logic               active,
    output logic               dwelling,
    output logic               done
);
    localparam int c_NWP = 2 ** AW;
    localparam int c_GW  = $clog2(GUARD + 1);
    localparam int c_DW  = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_DRIVE = 2'd1;
    localparam logic [1:0] c_DWELL = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]      r_state;
    logic [AW-1:0]   r_wp_idx;
    logic [W-1:0]    r_dx;
    logic [W-1:0]    r_dy;
    logic            r_loop;
    logic [AW-1:0]   r_last;
    logic [c_GW-1:0] r_guard;
    logic [c_DW-1:0] r_dwell;
    logic [W-1:0]    r_tab_x [c_NWP];
    logic [W-1:0]    r_tab_y [c_NWP];

    logic            w_idle_like;
    logic [AW-1:0]   w_next_idx;

    assign w_idle_like = (r_state == c_IDLE) || (r_state == c_DONE);
    assign w_next_idx  = r_wp_idx + AW'(1);

    assign bus.dX   = r_dx;
    assign bus.dY   = r_dy;
    assign wp_idx   = r_wp_idx;
    assign active   = (r_state == c_DRIVE) || (r_state == c_DWELL);
    assign dwelling = (r_state == c_DWELL);
    assign done     = (r_state == c_DONE);

    always_ff @(posedge outclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_wp_idx <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_loop   <= 1'b0;
            r_last   <= '0;
            r_guard  <= '0;
            r_dwell  <= '0;
            for (int i = 0; i < c_NWP; i++) begin
                r_tab_x[i] <= '0;
                r_tab_y[i] <= '0;
            end
        end else begin
            // Table is only writable while no run is in progress.
            if (w_idle_like && bus.wr_en) begin
                r_tab_x[bus.wr_addr] <= bus.wr_x;
                r_tab_y[bus.wr_addr] <= bus.wr_y;
            end

            if (abort) begin
                r_state <= c_IDLE;
            end else begin
                case (r_state)
                    c_IDLE, c_DONE: begin
                        if (start) begin
                            r_loop   <= loop;
                            r_last   <= wp_last;
                            r_wp_idx <= '0;
                            r_dx     <= r_tab_x[0];
                            r_dy     <= r_tab_y[0];
                            r_guard  <= c_GW'(GUARD);
                            r_state  <= c_DRIVE;
                        end
                    end
                    c_DRIVE: begin
                        if (r_guard != '0) begin
                            r_guard <= r_guard - 1'b1;
                        end else if (bus.arrived) begin
                            r_dwell <= c_DW'(DWELL - 1);
                            r_state <= c_DWELL;
                        end
                    end
                    c_DWELL: begin
                        if (r_dwell != '0) begin
                            r_dwell <= r_dwell - 1'b1;
                        end else if (r_wp_idx != r_last) begin
                            r_wp_idx <= w_next_idx;
                            r_dx     <= r_tab_x[w_next_idx];
                            r_dy     <= r_tab_y[w_next_idx];
                            r_guard  <= c_GW'(GUARD);
                            r_state  <= c_DRIVE;
                        end else if (r_loop) begin
                            r_wp_idx <= '0;
                            r_dx     <= r_tab_x[0];
                            r_dy     <= r_tab_y[0];
                            r_guard  <= c_GW'(GUARD);
                            r_state  <= c_DRIVE;
                        end else begin
                            r_state <= c_DONE;
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end
endmodule
`default_nettype wire
